// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, exception entry, FSM encodings.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned WORD_W  = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [WORD_W-1:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic [WORD_W-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Stall vectors: always a contiguous run of ones starting at the PC bit
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_PC   = 6'b000001;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Highest requesting stage wins; later stages freeze everything upstream
  function automatic logic [STALL_W-1:0] stall_encode(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [STALL_W-1:0] v;
    v = STALL_NONE;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, flush and PC redirect with a hold state
// while the fetch unit cannot take the redirect; saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             exc_valid,
  input  logic             exc_is_eret,
  input  logic [31:0]      cp0_epc,
  input  logic             if_ready,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [0:0]       r_state;
  logic [31:0]      r_held_pc;
  logic [CNT_W-1:0] r_stall_cycles;

  logic [0:0]       w_state_nxt;
  logic [31:0]      w_held_pc_nxt;
  logic [31:0]      w_exc_target;

  assign w_exc_target = exc_is_eret ? cp0_epc : EXC_VECTOR;

  // State and held redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_held_pc <= ZERO_WORD;
    end else begin
      r_state   <= w_state_nxt;
      r_held_pc <= w_held_pc_nxt;
    end
  end

  // Next state and combinational stall/flush/redirect; everything quiet in reset
  always_comb begin
    w_state_nxt    = r_state;
    w_held_pc_nxt  = r_held_pc;
    stall          = STALL_NONE;
    flush          = NO_STOP;
    redirect_valid = 1'b0;
    redirect_pc    = ZERO_WORD;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          if (exc_valid) begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = w_exc_target;
            if (!if_ready) begin
              w_state_nxt   = ST_HOLD;
              w_held_pc_nxt = w_exc_target;
            end
          end else begin
            stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
          end
        end
        ST_HOLD: begin
          stall          = STALL_PC;
          redirect_valid = 1'b1;
          redirect_pc    = r_held_pc;
          if (if_ready) w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Count cycles with the PC frozen, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if ((stall[0] == STOP) && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It gathers per-stage stall requests and the MEM-stage exception/ERET event and drives the 6-bit stall vector, the pipeline flush, and the PC redirect consumed by the PC register and the stage latches. A small FSM holds a pending redirect while the fetch unit cannot accept it. A saturating counter records stall cycles for performance debug.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry address
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
stallreq_if  in  1  IF stage requests stall (icache miss)
stallreq_id  in  1  ID stage requests stall (load-use hazard)
stallreq_ex  in  1  EX stage requests stall (mult/div busy)
stallreq_mem  in  1  MEM stage requests stall (dcache busy)
exc_valid  in  1  MEM stage commits an exception or ERET this cycle
exc_is_eret  in  1  qualifies exc_valid: 1 = ERET, 0 = exception
cp0_epc  in  32  EPC value from CP0, used when exc_is_eret=1
if_ready  in  1  fetch unit accepts a redirect this cycle
stall  out  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = Stop
flush  out  1  clear all stage latches
redirect_valid  out  1  redirect_pc is the next PC
redirect_pc  out  32  redirect target
stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1

Behaviour:
- States: RUN, HOLD. State, held target and counter are registered. stall, flush and redirect outputs are combinational from state and inputs.
- Reset values: state=RUN, held target=0, stall_cycles=0. Outputs while reset is high: stall=0, flush=0, redirect_valid=0, redirect_pc=0.
- RUN, exc_valid=0: no flush, no redirect. The stall vector follows the highest requesting stage:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
  - Multiple requests: the highest stage wins.
- The stall vector must always be a contiguous run of ones from bit 0. At PC, stall[0]=1 with stall[1]=0 inserts a bubble.
- RUN, exc_valid=1: exception beats every stall request in the same cycle.
  - Outputs: flush=1 for that cycle, stall=0, redirect_valid=1.
  - redirect_pc = cp0_epc if exc_is_eret, else EXC_VECTOR.
  - if_ready=1 → stay in RUN.
  - if_ready=0 → latch the target, go to HOLD.
- HOLD:
  - Outputs: flush=0, redirect_valid=1, redirect_pc=held target (stable), stall=6'b000001. Stage stall requests are ignored.
  - if_ready=1 → RUN on the next edge; the redirect is accepted in this cycle.
  - exc_valid in HOLD is ignored; the pipeline is already flushed.
- Latency: redirect accepted in the exception cycle (zero wait) or in the first HOLD cycle with if_ready=1. There is no timeout.
- Counter: increments on any cycle where stall[0]=1 (RUN or HOLD) and saturates at all-ones. Flush cycles do not count.
- Reset mid-HOLD: back to RUN and the held target is discarded.
- Reset has priority over all inputs.

Decomposition:
- Shared package/header (global_define.vh): Stop/NoStop, ZeroWord, stall-vector constants STALL_NONE/IF/ID/EX/MEM, EXC_VECTOR default, FSM state encodings.
- No sub-module is needed. The stall priority encoder can be a local function; a separate module is not justified.

Test Plan:
- Reset then idle with all requests at 0 → stall=0, flush=0, redirect_valid=0, stall_cycles=0.
- stallreq_id=1 and stallreq_ex=1 together for 3 cycles → stall=6'b001111 each cycle; stall_cycles=3 afterwards.
- exc_valid=1, exc_is_eret=0, if_ready=1, stallreq_mem=1 → same cycle flush=1, stall=0, redirect_pc=32'hBFC00380; next cycle state is RUN.
- exc_valid=1, exc_is_eret=1, cp0_epc=32'h80001234, if_ready=0 for 4 cycles:
  - exception cycle → flush=1, redirect_pc=32'h80001234.
  - next 4 cycles → HOLD with redirect_pc=32'h80001234 stable, stall=6'b000001, flush=0.
  - if_ready=1 → RUN; stall_cycles increased by 4.
- In HOLD, pulse exc_valid with a different target → held target unchanged, no flush.
- Reset asserted in HOLD → next cycle RUN, redirect_valid=0. Preloaded counter near CNT_W all-ones with stall held → saturates, no wrap.
